// File: rtl/data_arb_pkg.sv
// Shared types and helpers for the data_arb round-robin packet arbiter.
package data_arb_pkg;

  // Arbitration state: free to pick a new requester, or locked mid-packet.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  // Width of a requester index; at least one bit even for a single requester.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : data_arb_pkg

// File: rtl/data_arb_rr.sv
// Combinational rotate-priority picker: returns the first asserted request
// searching from ptr_i upwards, wrapping at N-1 back to 0.
module data_arb_rr
  import data_arb_pkg::*;
#(
  parameter  int N    = 4,
  localparam int ID_W = id_width(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [ID_W-1:0] gnt_idx_o,
  output logic            gnt_vld_o
);

  logic [ID_W-1:0] k;

  // Walk the requests in rotated order and keep the first hit.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves a value unassigned and infers a latch.
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    k         = '0;
    for (int i = 0; i < N; i++) begin
      k = ID_W'((int'(ptr_i) + i) % N);
      if (!gnt_vld_o && req_i[k]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = k;
      end
    end
  end

endmodule : data_arb_rr

// File: rtl/data_arb.sv
// Round-robin arbiter sharing one registered valid/ready output stage between
// N requesters. A requester keeps the grant from its first beat through the
// beat flagged last; the pointer only advances once a packet completes.
module data_arb
  import data_arb_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int WIDTH = 32,
  localparam int ID_W  = id_width(N)
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [N-1:0][WIDTH-1:0]   in_data_i,
  input  logic [N-1:0]              in_last_i,
  input  logic [N-1:0]              in_valid_i,
  output logic [N-1:0]              in_ready_o,
  output logic [WIDTH-1:0]          out_data_o,
  output logic                      out_last_o,
  output logic [ID_W-1:0]           out_id_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i
);

  arb_state_t       state_q;
  logic [ID_W-1:0]  ptr_q;
  logic [ID_W-1:0]  lk_q;

  logic [WIDTH-1:0] out_data_q;
  logic             out_last_q;
  logic [ID_W-1:0]  out_id_q;
  logic             out_valid_q;

  logic             stage_ready;
  logic [ID_W-1:0]  rr_idx;
  logic             rr_vld;
  logic [ID_W-1:0]  cand_idx;
  logic             cand_vld;
  logic             xfer;
  logic [ID_W-1:0]  next_ptr;

  // Output stage can take a beat when empty or being drained this cycle.
  assign stage_ready = out_ready_i | ~out_valid_q;

  data_arb_rr #(
    .N (N)
  ) u_rr (
    .req_i     (in_valid_i),
    .ptr_i     (ptr_q),
    .gnt_idx_o (rr_idx),
    .gnt_vld_o (rr_vld)
  );

  // Pick the candidate: the locked requester mid-packet, else the rr winner.
  // The ready mux never looks at data or last, only at valids and state.
  always_comb begin
    cand_idx   = rr_idx;
    cand_vld   = rr_vld;
    in_ready_o = '0;
    if (state_q == ARB_LOCK) begin
      cand_idx = lk_q;
      cand_vld = 1'b1;
    end
    if (cand_vld) begin
      in_ready_o[cand_idx] = stage_ready;
    end
  end

  assign xfer     = cand_vld & stage_ready & in_valid_i[cand_idx];
  assign next_ptr = (cand_idx == ID_W'(N - 1)) ? '0 : cand_idx + ID_W'(1);

  // Arbitration FSM: lock on a non-last beat, release and rotate on last.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      lk_q    <= '0;
    end else if (xfer) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (in_last_i[cand_idx]) begin
        state_q <= ARB_IDLE;
        ptr_q   <= next_ptr;
      end else begin
        state_q <= ARB_LOCK;
        lk_q    <= cand_idx;
      end
    end
  end

  // Output register stage: load on transfer, empty when drained, else hold.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_id_q    <= '0;
      out_valid_q <= 1'b0;
    end else if (stage_ready) begin
      if (xfer) begin
        out_data_q  <= in_data_i[cand_idx];
        out_last_q  <= in_last_i[cand_idx];
        out_id_q    <= cand_idx;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign out_id_o    = out_id_q;
  assign out_valid_o = out_valid_q;

endmodule : data_arb
